// File: rtl/seg7_code_pkg.sv
// Shared definitions for the 5-bit code + parity link to the 7-segment decoder.
// Both the transmitter and the decoder side import this package.
package seg7_code_pkg;
   localparam int CODE_W = 5;
   localparam logic [CODE_W-1:0] MAX_CODE_DEF = 5'd20;

   typedef enum logic [1:0] {IDLE, HOLD, AUTO} state_t;
endpackage

// File: rtl/seg7_dwell_tick.sv
// Dwell timer: counts enabled cycles and pulses tick on the last cycle of each
// DWELL_CYCLES window, restarting from zero on that same edge.
module seg7_dwell_tick #(
   parameter int DWELL_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(DWELL_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/seg7_code_tx.sv
// Code + parity source for the 7-segment decoder: handshake loads or auto-count.
// Build option PARITY_ERR_INJECT_EN adds inj_err to deliberately flip parity.
module seg7_code_tx
   import seg7_code_pkg::*;
#(
   parameter int                DWELL_CYCLES = 8,
   parameter logic [CODE_W-1:0] MAX_CODE     = MAX_CODE_DEF
) (
`ifdef PARITY_ERR_INJECT_EN
   input  logic              inj_err,
`endif
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [CODE_W-1:0] load_value,
   output logic              load_ready,
   input  logic              auto_en,
   output logic              A,
   output logic              B,
   output logic              C,
   output logic              D,
   output logic              E,
   output logic              Parity,
   output logic              out_valid,
   output logic              range_err
);
   state_t            state, state_n;
   logic [CODE_W-1:0] code, code_n;
   logic              par_n, vld_n, rerr_n;
   logic              inj, tick, dw_en, dw_clr;

`ifdef PARITY_ERR_INJECT_EN
   assign inj = inj_err;
`else
   assign inj = 1'b0;
`endif

   assign load_ready = (state != AUTO) && !auto_en;
   assign {A, B, C, D, E} = code;

   // Timer only runs while auto mode is active and continuing; any other
   // cycle holds it at zero so every AUTO entry starts a fresh dwell.
   assign dw_en  = (state == AUTO) && auto_en;
   assign dw_clr = !dw_en;

   seg7_dwell_tick #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .clr  (dw_clr),
      .en   (dw_en),
      .tick (tick)
   );

   always_comb begin
      state_n = state;
      code_n  = code;
      par_n   = Parity;
      vld_n   = out_valid;
      rerr_n  = 1'b0;
      case (state)
         IDLE, HOLD: begin
            if (auto_en) begin
               state_n = AUTO;
               code_n  = '0;
               par_n   = 1'b0;
               vld_n   = 1'b1;
            end else if (load_valid) begin
               if (load_value > MAX_CODE) begin
                  rerr_n = 1'b1;
               end else begin
                  state_n = HOLD;
                  code_n  = load_value;
                  par_n   = (^load_value) ^ inj;
                  vld_n   = 1'b1;
               end
            end
         end
         AUTO: begin
            // Dropping auto_en wins over a coincident step: the shown code freezes.
            if (!auto_en) begin
               state_n = HOLD;
            end else if (tick) begin
               code_n = (code >= MAX_CODE) ? '0 : code + 5'd1;
               par_n  = (^code_n) ^ inj;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         code      <= '0;
         Parity    <= 1'b0;
         out_valid <= 1'b0;
         range_err <= 1'b0;
      end else begin
         state     <= state_n;
         code      <= code_n;
         Parity    <= par_n;
         out_valid <= vld_n;
         range_err <= rerr_n;
      end
   end
endmodule

// File: tb/tb_seg7_code_tx.sv
// Directed self-checking bench for seg7_code_tx (DWELL_CYCLES=2, MAX_CODE=20).
// Define PARITY_ERR_INJECT_EN to also cover parity injection.
module tb_seg7_code_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_valid = 1'b0;
   logic [4:0] load_value = 5'd0;
   logic       auto_en = 1'b0;
   logic       inj_err = 1'b0;
   logic       load_ready, A, B, C, D, E, Parity, out_valid, range_err;
   int         checks = 0;
   int         fails = 0;

   seg7_code_tx #(.DWELL_CYCLES(2), .MAX_CODE(5'd20)) dut (
`ifdef PARITY_ERR_INJECT_EN
      .inj_err    (inj_err),
`endif
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_value (load_value),
      .load_ready (load_ready),
      .auto_en    (auto_en),
      .A          (A),
      .B          (B),
      .C          (C),
      .D          (D),
      .E          (E),
      .Parity     (Parity),
      .out_valid  (out_valid),
      .range_err  (range_err)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({A,B,C,D,E,Parity,out_valid,range_err} !== 8'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 00000000", {A,B,C,D,E,Parity,out_valid,range_err});
      end
      rst = 1'b0;
      checks++;
      if (load_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: got %b want 1", load_ready);
      end
   endtask

   task automatic test_load();
      load_valid = 1'b1;
      load_value = 5'd6;
      step();
      load_valid = 1'b0;
      checks++;
      if ({A,B,C,D,E,Parity,out_valid,range_err} !== 8'b00110_010) begin
         fails++;
         $display("FAIL load6: got %b want 00110010", {A,B,C,D,E,Parity,out_valid,range_err});
      end
      // MAX_CODE itself is legal
      load_valid = 1'b1;
      load_value = 5'd20;
      step();
      load_valid = 1'b0;
      checks++;
      if ({A,B,C,D,E,Parity,range_err} !== 7'b10100_0_0) begin
         fails++;
         $display("FAIL load20: got %b want 1010000", {A,B,C,D,E,Parity,range_err});
      end
   endtask

   task automatic test_back_to_back();
      load_valid = 1'b1;
      load_value = 5'd7;
      step();
      checks++;
      if ({A,B,C,D,E,Parity,range_err} !== 7'b00111_1_0) begin
         fails++;
         $display("FAIL b2b_load7: got %b want 0011110", {A,B,C,D,E,Parity,range_err});
      end
      load_value = 5'd21;
      step();
      load_valid = 1'b0;
      checks++;
      if ({A,B,C,D,E,Parity,range_err} !== 7'b00111_1_1) begin
         fails++;
         $display("FAIL b2b_reject21: got %b want 0011111", {A,B,C,D,E,Parity,range_err});
      end
      step();
      checks++;
      if ({A,B,C,D,E,range_err} !== 6'b00111_0) begin
         fails++;
         $display("FAIL rerr_one_cycle: got %b want 001110", {A,B,C,D,E,range_err});
      end
      load_valid = 1'b1;
      load_value = 5'd31;
      step();
      load_valid = 1'b0;
      checks++;
      if ({A,B,C,D,E,range_err} !== 6'b00111_1) begin
         fails++;
         $display("FAIL reject31: got %b want 001111", {A,B,C,D,E,range_err});
      end
   endtask

   // Sample k (k=0 is the entry edge) shows code (k/2) mod 21.
   task automatic test_auto();
      logic [4:0] exp;
      auto_en = 1'b1;
      #1;
      checks++;
      if (load_ready !== 1'b0) begin
         fails++;
         $display("FAIL auto_ready_pre: got %b want 0", load_ready);
      end
      for (int k = 0; k < 44; k++) begin
         load_valid = (k >= 10 && k < 14);
         load_value = 5'd3;
         step();
         exp = 5'((k / 2) % 21);
         checks++;
         if ({A,B,C,D,E} !== exp || Parity !== ^exp || out_valid !== 1'b1 ||
             load_ready !== 1'b0 || range_err !== 1'b0) begin
            fails++;
            $display("FAIL auto_seq k=%0d: got code=%0d par=%b vld=%b rdy=%b rerr=%b want code=%0d par=%b vld=1 rdy=0 rerr=0",
                     k, {A,B,C,D,E}, Parity, out_valid, load_ready, range_err, exp, ^exp);
         end
      end
      load_valid = 1'b0;
   endtask

   // Continues auto from k=43 up to the first cycle of code 13, then freezes.
   task automatic test_freeze();
      for (int k = 44; k <= 68; k++) step();
      checks++;
      if ({A,B,C,D,E} !== 5'd13) begin
         fails++;
         $display("FAIL freeze_pre: got %0d want 13", {A,B,C,D,E});
      end
      auto_en = 1'b0;
      step();
      checks++;
      if ({A,B,C,D,E,Parity,out_valid,load_ready} !== 8'b01101_1_1_1) begin
         fails++;
         $display("FAIL freeze_hold: got %b want 01101111", {A,B,C,D,E,Parity,out_valid,load_ready});
      end
      step();
      step();
      step();
      checks++;
      if ({A,B,C,D,E,Parity} !== 6'b01101_1) begin
         fails++;
         $display("FAIL freeze_stays: got %b want 011011", {A,B,C,D,E,Parity});
      end
   endtask

   task automatic test_reset_mid();
      auto_en = 1'b1;
      for (int k = 0; k <= 19; k++) step();
      checks++;
      if ({A,B,C,D,E} !== 5'd9) begin
         fails++;
         $display("FAIL mid_pre: got %0d want 9", {A,B,C,D,E});
      end
      rst = 1'b1;
      step();
      checks++;
      if ({A,B,C,D,E,Parity,out_valid,range_err} !== 8'b0) begin
         fails++;
         $display("FAIL mid_reset: got %b want 00000000", {A,B,C,D,E,Parity,out_valid,range_err});
      end
      rst = 1'b0;
      step();
      step();
      checks++;
      if ({A,B,C,D,E,out_valid} !== 6'b00000_1) begin
         fails++;
         $display("FAIL restart_hold0: got %b want 000001", {A,B,C,D,E,out_valid});
      end
      step();
      checks++;
      if ({A,B,C,D,E,Parity} !== 6'b00001_1) begin
         fails++;
         $display("FAIL restart_step1: got %b want 000011", {A,B,C,D,E,Parity});
      end
      auto_en = 1'b0;
      step();
   endtask

`ifdef PARITY_ERR_INJECT_EN
   task automatic test_inject();
      load_valid = 1'b1;
      load_value = 5'd5;
      inj_err    = 1'b1;
      step();
      inj_err = 1'b0;
      checks++;
      if ({A,B,C,D,E,Parity} !== 6'b00101_1) begin
         fails++;
         $display("FAIL inj_corrupt: got %b want 001011", {A,B,C,D,E,Parity});
      end
      step();
      load_valid = 1'b0;
      checks++;
      if ({A,B,C,D,E,Parity} !== 6'b00101_0) begin
         fails++;
         $display("FAIL inj_revert: got %b want 001010", {A,B,C,D,E,Parity});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_auto();
      test_freeze();
      test_reset_mid();
`ifdef PARITY_ERR_INJECT_EN
      test_inject();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
